// File: rtl/fft2d_pass_ctrl_if.sv
// Handshake/strobe bundle between the 2-D FFT pass sequencer and its
// surroundings (input selecter, 1-D FFT core, output selecter, downstream).
//   master : the sequencer side (drives in_ready, fft_start, sel_feedback,
//            rt_load, out_load, out_valid; samples in_valid, fft_done, out_ready)
//   slave  : the environment side (the reverse directions)
interface fft2d_pass_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic fft_start;
  logic fft_done;
  logic sel_feedback;
  logic rt_load;
  logic out_load;
  logic out_valid;
  logic out_ready;

  modport master (
    input  in_valid, fft_done, out_ready,
    output in_ready, fft_start, sel_feedback, rt_load, out_load, out_valid
  );

  modport slave (
    output in_valid, fft_done, out_ready,
    input  in_ready, fft_start, sel_feedback, rt_load, out_load, out_valid
  );
endinterface

// File: rtl/fft2d_pass_ctrl.sv
// Sequencer for the 4x4 2-D FFT. One frame is a row pass on the external input
// followed by a column pass on the transposed feedback data; the finished frame
// is then offered downstream with a valid/ready handshake.
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous reset, active-low
//   bus          handshake/strobe bundle (master side), see fft2d_pass_ctrl_if
//   abort        synchronous abort back to IDLE from any busy state
//   clr_err      leaves ERR and clears err_timeout
//   busy         high in every state except IDLE
//   pass_idx     0 = row pass, 1 = column pass
//   err_timeout  sticky FFT-core timeout flag
//   frame_cnt    completed frames, wraps modulo 2^FRAME_W
module fft2d_pass_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned FRAME_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fft2d_pass_ctrl_if.master    bus,
  input  logic                 abort,
  input  logic                 clr_err,
  output logic                 busy,
  output logic                 pass_idx,
  output logic                 err_timeout,
  output logic [FRAME_W-1:0]   frame_cnt
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_RUN,
    S_ROW_WAIT,
    S_ROW_CAPT,
    S_COL_RUN,
    S_COL_WAIT,
    S_OUT_HOLD,
    S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // All outputs are registered and updated on the edge that enters the state
  // they belong to. out_load is issued on the edge that sees the column-pass
  // fft_done (mirroring rt_load after the row pass); out_valid rises one cycle
  // later, once out_* actually holds the frame, and the downstream handshake is
  // only honoured while out_valid is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      frame_cnt        <= '0;
      bus.in_ready     <= 1'b1;
      bus.fft_start    <= 1'b0;
      bus.sel_feedback <= 1'b0;
      bus.rt_load      <= 1'b0;
      bus.out_load     <= 1'b0;
      bus.out_valid    <= 1'b0;
      busy             <= 1'b0;
      pass_idx         <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      bus.fft_start <= 1'b0;
      bus.rt_load   <= 1'b0;
      bus.out_load  <= 1'b0;

      if (abort && state != S_IDLE) begin
        state            <= S_IDLE;
        bus.in_ready     <= 1'b1;
        bus.sel_feedback <= 1'b0;
        bus.out_valid    <= 1'b0;
        busy             <= 1'b0;
        pass_idx         <= 1'b0;
        err_timeout      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.in_valid && !abort) begin
              state            <= S_ROW_RUN;
              bus.in_ready     <= 1'b0;
              busy             <= 1'b1;
              bus.fft_start    <= 1'b1;
              bus.sel_feedback <= 1'b0;
              pass_idx         <= 1'b0;
            end
          end

          S_ROW_RUN: begin
            state    <= S_ROW_WAIT;
            wait_cnt <= '0;
          end

          S_ROW_WAIT: begin
            if (bus.fft_done) begin
              state       <= S_ROW_CAPT;
              bus.rt_load <= 1'b1;
            end else if (wait_cnt == CNT_LAST) begin
              state       <= S_ERR;
              err_timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end

          S_ROW_CAPT: begin
            state            <= S_COL_RUN;
            bus.fft_start    <= 1'b1;
            bus.sel_feedback <= 1'b1;
            pass_idx         <= 1'b1;
          end

          S_COL_RUN: begin
            state    <= S_COL_WAIT;
            wait_cnt <= '0;
          end

          S_COL_WAIT: begin
            if (bus.fft_done) begin
              state            <= S_OUT_HOLD;
              bus.out_load     <= 1'b1;
              bus.sel_feedback <= 1'b0;
              pass_idx         <= 1'b0;
            end else if (wait_cnt == CNT_LAST) begin
              state            <= S_ERR;
              err_timeout      <= 1'b1;
              bus.sel_feedback <= 1'b0;
              pass_idx         <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end

          S_OUT_HOLD: begin
            if (bus.out_valid && bus.out_ready) begin
              state         <= S_IDLE;
              bus.out_valid <= 1'b0;
              bus.in_ready  <= 1'b1;
              busy          <= 1'b0;
              frame_cnt     <= frame_cnt + FRAME_W'(1);
            end else begin
              bus.out_valid <= 1'b1;
            end
          end

          S_ERR: begin
            if (clr_err) begin
              state        <= S_IDLE;
              err_timeout  <= 1'b0;
              bus.in_ready <= 1'b1;
              busy         <= 1'b0;
            end
          end

          default: begin
            state        <= S_IDLE;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
